// File: rtl/npu_pkg.sv
// Shared NPU definitions: default datapath widths, pooling limit and the
// writeback FSM encoding.
package npu_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 12;
    localparam int POOL_MAX   = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } wb_state_e;

    // A zero length means "no pooling"; lengths beyond the hardware limit saturate.
    function automatic logic [2:0] norm_pool_len(input logic [2:0] len);
        logic [2:0] r;
        if (len == 3'd0) begin
            r = 3'd1;
        end else if (len > 3'(POOL_MAX)) begin
            r = 3'(POOL_MAX);
        end else begin
            r = len;
        end
        return r;
    endfunction

endpackage

// File: rtl/npu_act_writeback_if.sv
// MAC result stream into the writeback stage and the activation-memory write
// port out of it.
interface npu_act_writeback_if #(
    parameter int DATA_WIDTH = npu_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = npu_pkg::ADDR_WIDTH
);
    import npu_pkg::*;

    logic                         mac_valid;
    logic signed [DATA_WIDTH-1:0] mac_out;
    logic                         mac_overflow;
    logic                         act_wr_en;
    logic [ADDR_WIDTH-1:0]        act_wr_addr;
    logic [DATA_WIDTH-1:0]        act_wr_data;

    modport master (
        output mac_valid, mac_out, mac_overflow,
        input  act_wr_en, act_wr_addr, act_wr_data
    );

    modport slave (
        input  mac_valid, mac_out, mac_overflow,
        output act_wr_en, act_wr_addr, act_wr_data
    );

endinterface

// File: rtl/npu_pool_max.sv
// ReLU clamp followed by a signed running maximum over groups of pool_len
// samples; pool_val is the group result including the current sample.
module npu_pool_max #(
    parameter int DATA_WIDTH = npu_pkg::DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         in_valid,
    input  logic                         relu_en,
    input  logic [2:0]                   pool_len,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         grp_last,
    output logic signed [DATA_WIDTH-1:0] pool_val
);
    import npu_pkg::*;

    logic [2:0]                   grp_cnt_q, grp_cnt_d;
    logic signed [DATA_WIDTH-1:0] max_q, max_d;
    logic signed [DATA_WIDTH-1:0] clamp_s;

    // Clamp, running max and group bookkeeping.
    always_comb begin
        clamp_s   = in_data;
        pool_val  = max_q;
        grp_cnt_d = grp_cnt_q;
        max_d     = max_q;

        if (relu_en && in_data[DATA_WIDTH-1]) begin
            clamp_s = '0;
        end else begin
            clamp_s = in_data;
        end

        if (grp_cnt_q == 3'd0) begin
            pool_val = clamp_s;
        end else if (clamp_s > max_q) begin
            pool_val = clamp_s;
        end else begin
            pool_val = max_q;
        end

        grp_last = in_valid && (grp_cnt_q == (pool_len - 3'd1));

        if (clear) begin
            grp_cnt_d = 3'd0;
            max_d     = '0;
        end else if (in_valid) begin
            max_d     = pool_val;
            grp_cnt_d = grp_last ? 3'd0 : (grp_cnt_q + 3'd1);
        end else begin
            grp_cnt_d = grp_cnt_q;
            max_d     = max_q;
        end
    end

    // Group state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            grp_cnt_q <= 3'd0;
            max_q     <= '0;
        end else begin
            grp_cnt_q <= grp_cnt_d;
            max_q     <= max_d;
        end
    end

endmodule

// File: rtl/npu_act_writeback.sv
// Activation/writeback stage: layer FSM, sequential activation-memory writes
// of pooled MAC results, and per-layer status flags.
module npu_act_writeback #(
    parameter int DATA_WIDTH = npu_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = npu_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  layer_start,
    input  logic                  relu_en,
    input  logic [2:0]            pool_len,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] out_count,
    npu_act_writeback_if.slave    bus,
    output logic                  layer_done,
    output logic                  busy,
    output logic                  ovf_sticky,
    output logic                  stray_valid
);
    import npu_pkg::*;

    wb_state_e             state_q, state_d;
    logic                  relu_q, relu_d;
    logic [2:0]            pool_len_q, pool_len_d;
    logic [ADDR_WIDTH-1:0] out_count_q, out_count_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
    logic [ADDR_WIDTH-1:0] wr_cnt_inc_s;
    logic                  act_wr_en_q, act_wr_en_d;
    logic [ADDR_WIDTH-1:0] act_wr_addr_q, act_wr_addr_d;
    logic [DATA_WIDTH-1:0] act_wr_data_q, act_wr_data_d;
    logic                  layer_done_q, layer_done_d;
    logic                  busy_q, busy_d;
    logic                  ovf_q, ovf_d;
    logic                  stray_q, stray_d;

    logic                         pool_valid_s;
    logic                         grp_last_s;
    logic signed [DATA_WIDTH-1:0] pool_val_s;

    // A sample coinciding with layer_start belongs to neither layer and is dropped.
    assign pool_valid_s = bus.mac_valid && (state_q == ST_RUN) && !layer_start;

    npu_pool_max #(.DATA_WIDTH(DATA_WIDTH)) u_pool (
        .clk      (clk),
        .rst      (rst),
        .clear    (layer_start),
        .in_valid (pool_valid_s),
        .relu_en  (relu_q),
        .pool_len (pool_len_q),
        .in_data  (bus.mac_out),
        .grp_last (grp_last_s),
        .pool_val (pool_val_s)
    );

    // Next-state, write issue and flag update.
    always_comb begin
        state_d       = state_q;
        relu_d        = relu_q;
        pool_len_d    = pool_len_q;
        out_count_d   = out_count_q;
        wr_addr_d     = wr_addr_q;
        wr_cnt_d      = wr_cnt_q;
        wr_cnt_inc_s  = wr_cnt_q + ADDR_WIDTH'(1);
        act_wr_en_d   = 1'b0;
        act_wr_addr_d = act_wr_addr_q;
        act_wr_data_d = act_wr_data_q;
        layer_done_d  = 1'b0;
        ovf_d         = ovf_q;
        stray_d       = stray_q;

        if (layer_start) begin
            relu_d      = relu_en;
            pool_len_d  = norm_pool_len(pool_len);
            out_count_d = out_count;
            wr_addr_d   = base_addr;
            wr_cnt_d    = '0;
            ovf_d       = 1'b0;
            stray_d     = 1'b0;
            if (out_count == '0) begin
                layer_done_d = 1'b1;
                state_d      = ST_IDLE;
            end else begin
                state_d      = ST_RUN;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.mac_valid) begin
                        stray_d = 1'b1;
                    end else begin
                        stray_d = stray_q;
                    end
                end
                ST_RUN: begin
                    if (bus.mac_overflow) begin
                        ovf_d = 1'b1;
                    end else begin
                        ovf_d = ovf_q;
                    end
                    if (grp_last_s) begin
                        act_wr_en_d   = 1'b1;
                        act_wr_addr_d = wr_addr_q;
                        act_wr_data_d = pool_val_s;
                        wr_addr_d     = wr_addr_q + ADDR_WIDTH'(1);
                        wr_cnt_d      = wr_cnt_inc_s;
                        if (wr_cnt_inc_s == out_count_q) begin
                            layer_done_d = 1'b1;
                            state_d      = ST_IDLE;
                        end else begin
                            state_d      = ST_RUN;
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // busy stays up through the done pulse and drops the cycle after.
        busy_d = (state_d == ST_RUN) || layer_done_d;
    end

    // State, config and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            relu_q        <= 1'b0;
            pool_len_q    <= 3'd1;
            out_count_q   <= '0;
            wr_addr_q     <= '0;
            wr_cnt_q      <= '0;
            act_wr_en_q   <= 1'b0;
            act_wr_addr_q <= '0;
            act_wr_data_q <= '0;
            layer_done_q  <= 1'b0;
            busy_q        <= 1'b0;
            ovf_q         <= 1'b0;
            stray_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            relu_q        <= relu_d;
            pool_len_q    <= pool_len_d;
            out_count_q   <= out_count_d;
            wr_addr_q     <= wr_addr_d;
            wr_cnt_q      <= wr_cnt_d;
            act_wr_en_q   <= act_wr_en_d;
            act_wr_addr_q <= act_wr_addr_d;
            act_wr_data_q <= act_wr_data_d;
            layer_done_q  <= layer_done_d;
            busy_q        <= busy_d;
            ovf_q         <= ovf_d;
            stray_q       <= stray_d;
        end
    end

    assign bus.act_wr_en   = act_wr_en_q;
    assign bus.act_wr_addr = act_wr_addr_q;
    assign bus.act_wr_data = act_wr_data_q;
    assign layer_done      = layer_done_q;
    assign busy            = busy_q;
    assign ovf_sticky      = ovf_q;
    assign stray_valid     = stray_q;

endmodule

// File: tb/tb_npu_act_writeback.sv
// Scoreboard bench for npu_act_writeback: a behavioural layer model queues
// expected writes as MAC samples are driven; a monitor pops and compares them.
module tb_npu_act_writeback;

    typedef struct {
        logic [11:0] addr;
        logic [15:0] data;
        logic        done;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        layer_start = 1'b0;
    logic        relu_en = 1'b0;
    logic [2:0]  pool_len = 3'd0;
    logic [11:0] base_addr = 12'd0;
    logic [11:0] out_count = 12'd0;
    logic        layer_done, busy, ovf_sticky, stray_valid;

    npu_act_writeback_if bus ();

    npu_act_writeback dut (
        .clk         (clk),
        .rst         (rst),
        .layer_start (layer_start),
        .relu_en     (relu_en),
        .pool_len    (pool_len),
        .base_addr   (base_addr),
        .out_count   (out_count),
        .bus         (bus.slave),
        .layer_done  (layer_done),
        .busy        (busy),
        .ovf_sticky  (ovf_sticky),
        .stray_valid (stray_valid)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    int   done_cnt = 0;
    int   wr_seen = 0;
    int   m_pushed = 0;

    // Layer model state
    logic        m_run = 1'b0;
    logic        m_relu = 1'b0;
    int          m_pool = 1;
    int          m_g = 0;
    logic signed [15:0] m_max = 16'sd0;
    logic [11:0] m_addr = 12'd0;
    logic [11:0] m_wcnt = 12'd0;
    logic [11:0] m_out = 12'd0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Write monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        exp_t e;
        if (layer_done) done_cnt++;
        if (bus.act_wr_en) begin
            wr_seen++;
            check_eq("wr_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_eq("wr_addr", 32'(bus.act_wr_addr), 32'(e.addr));
                check_eq("wr_data", 32'(bus.act_wr_data), 32'(e.data));
                check_eq("wr_done", 32'(layer_done), 32'(e.done));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_layer(input logic relu, input logic [2:0] pl, input logic [11:0] base,
                               input logic [11:0] cnt, input logic with_valid);
        layer_start   = 1'b1;
        relu_en       = relu;
        pool_len      = pl;
        base_addr     = base;
        out_count     = cnt;
        bus.mac_valid = with_valid;
        bus.mac_out   = 16'sd99;
        m_relu = relu;
        m_pool = (pl == 3'd0) ? 1 : int'(pl);
        m_addr = base;
        m_out  = cnt;
        m_wcnt = 12'd0;
        m_g    = 0;
        m_run  = (cnt != 12'd0);
        step();
        layer_start   = 1'b0;
        bus.mac_valid = 1'b0;
    endtask

    task automatic mac(input logic signed [15:0] v, input logic ovf);
        logic signed [15:0] vv;
        exp_t e;
        bus.mac_valid    = 1'b1;
        bus.mac_out      = v;
        bus.mac_overflow = ovf;
        if (m_run) begin
            vv = (m_relu && v < 0) ? 16'sd0 : v;
            if (m_g == 0 || vv > m_max) m_max = vv;
            m_g++;
            if (m_g == m_pool) begin
                m_g    = 0;
                e.addr = m_addr;
                e.data = m_max;
                e.done = ((m_wcnt + 12'd1) == m_out);
                sb.push_back(e);
                m_pushed++;
                m_addr = m_addr + 12'd1;
                m_wcnt = m_wcnt + 12'd1;
                if (e.done) m_run = 1'b0;
            end
        end
        step();
        bus.mac_valid    = 1'b0;
        bus.mac_overflow = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    initial begin
        int d0;
        int w0;
        bus.mac_valid    = 1'b0;
        bus.mac_out      = 16'sd0;
        bus.mac_overflow = 1'b0;

        // Reset state
        idle(3);
        check_eq("rst_wr_en",   32'(bus.act_wr_en), 32'd0);
        check_eq("rst_wr_addr", 32'(bus.act_wr_addr), 32'd0);
        check_eq("rst_wr_data", 32'(bus.act_wr_data), 32'd0);
        check_eq("rst_done",    32'(layer_done), 32'd0);
        check_eq("rst_busy",    32'(busy), 32'd0);
        check_eq("rst_ovf",     32'(ovf_sticky), 32'd0);
        check_eq("rst_stray",   32'(stray_valid), 32'd0);
        rst = 1'b0;
        idle(1);

        // No pooling, no ReLU, back-to-back samples
        d0 = done_cnt;
        start_layer(1'b0, 3'd1, 12'h010, 12'd3, 1'b0);
        check_eq("busy_after_start", 32'(busy), 32'd1);
        mac(-16'sd5, 1'b0);
        mac(16'sd7, 1'b0);
        mac(-16'sd1, 1'b0);
        idle(1);
        check_eq("busy_after_done", 32'(busy), 32'd0);
        idle(1);
        check_eq("l1_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Pool of 4 with ReLU: expect 9 then 0
        d0 = done_cnt;
        start_layer(1'b1, 3'd4, 12'h020, 12'd2, 1'b0);
        mac(-16'sd3, 1'b0); mac(16'sd2, 1'b0); mac(16'sd9, 1'b0); mac(16'sd1, 1'b0);
        mac(-16'sd8, 1'b0); mac(-16'sd2, 1'b0); mac(-16'sd7, 1'b0); mac(-16'sd1, 1'b0);
        idle(2);
        check_eq("l2_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Address wrap at top of memory
        start_layer(1'b0, 3'd1, 12'hFFE, 12'd3, 1'b0);
        mac(16'sd11, 1'b0); mac(16'sd22, 1'b0); mac(-16'sd33, 1'b0);
        idle(2);

        // Abort after two of four writes, restart at 0x100
        d0 = done_cnt;
        start_layer(1'b0, 3'd1, 12'h200, 12'd4, 1'b0);
        mac(16'sd1, 1'b0); mac(16'sd2, 1'b0);
        idle(1);
        check_eq("abort_no_done", 32'(done_cnt - d0), 32'd0);
        start_layer(1'b0, 3'd1, 12'h100, 12'd1, 1'b0);
        mac(16'sd5, 1'b0);
        idle(2);
        check_eq("abort_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Sample in IDLE is stray; layer_start clears it and drops a coincident sample
        w0 = wr_seen;
        mac(16'sd3, 1'b0);
        check_eq("stray_set", 32'(stray_valid), 32'd1);
        idle(1);
        check_eq("stray_no_wr", 32'(wr_seen - w0), 32'd0);
        start_layer(1'b0, 3'd2, 12'h300, 12'd1, 1'b1);
        check_eq("stray_cleared", 32'(stray_valid), 32'd0);
        check_eq("ovf_clear0", 32'(ovf_sticky), 32'd0);
        mac(16'sd4, 1'b1);
        check_eq("ovf_set", 32'(ovf_sticky), 32'd1);
        mac(16'sd6, 1'b0);
        idle(2);
        check_eq("ovf_held", 32'(ovf_sticky), 32'd1);

        // Empty layer: done one cycle after start, no writes, overflow flag cleared
        d0 = done_cnt;
        w0 = wr_seen;
        start_layer(1'b0, 3'd1, 12'h500, 12'd0, 1'b0);
        check_eq("empty_done", 32'(layer_done), 32'd1);
        check_eq("ovf_cleared", 32'(ovf_sticky), 32'd0);
        idle(2);
        check_eq("empty_done_cnt", 32'(done_cnt - d0), 32'd1);
        check_eq("empty_no_wr", 32'(wr_seen - w0), 32'd0);
        check_eq("empty_busy", 32'(busy), 32'd0);

        // Reset mid-layer
        d0 = done_cnt;
        start_layer(1'b0, 3'd1, 12'h400, 12'd4, 1'b0);
        mac(16'sd1, 1'b1);
        idle(1);
        rst              = 1'b1;
        bus.mac_valid    = 1'b1;
        bus.mac_out      = 16'sd9;
        m_run            = 1'b0;
        step();
        bus.mac_valid    = 1'b0;
        check_eq("mrst_wr_en",   32'(bus.act_wr_en), 32'd0);
        check_eq("mrst_wr_addr", 32'(bus.act_wr_addr), 32'd0);
        check_eq("mrst_wr_data", 32'(bus.act_wr_data), 32'd0);
        check_eq("mrst_busy",    32'(busy), 32'd0);
        check_eq("mrst_ovf",     32'(ovf_sticky), 32'd0);
        check_eq("mrst_done",    32'(layer_done), 32'd0);
        rst = 1'b0;
        w0  = wr_seen;
        mac(16'sd7, 1'b0);
        idle(2);
        check_eq("mrst_ignored", 32'(wr_seen - w0), 32'd0);
        check_eq("mrst_stray",   32'(stray_valid), 32'd1);
        check_eq("mrst_no_done", 32'(done_cnt - d0), 32'd0);

        // Every queued write must have been seen
        check_eq("sb_empty",    32'(sb.size()), 32'd0);
        check_eq("total_writes", 32'(wr_seen), 32'(m_pushed));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
